rotary_counter: RTL and testbench

- Downstream consumer of the rotary encoder decoder.
- Takes its latched event flags (rotl, rotr, push) and acknowledges each event through the decoder's `read` input.
- Maintains a bounded position value that steps by a normal or fast increment; push toggles between the two.
- Drives the position and an update strobe toward display/application logic.

---
 rtl/rotary_counter_if.sv | 26 ++
 rtl/rotary_counter.sv | 94 +++++++++
 tb/tb_rotary_counter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/rotary_counter_if.sv
// Event/acknowledge link between the encoder decoder and the position counter,
// plus the position outputs toward display/application logic.
interface rotary_counter_if #(
  parameter int WIDTH = 8
);
  logic             rotl_in;
  logic             rotr_in;
  logic             push_in;
  logic             read;
  logic [WIDTH-1:0] value;
  logic             fast;
  logic             upd;
  logic             err;

  // decoder / stimulus side
  modport master (
    output rotl_in, rotr_in, push_in,
    input  read, value, fast, upd, err
  );

  // counter side
  modport slave (
    input  rotl_in, rotr_in, push_in,
    output read, value, fast, upd, err
  );
endinterface

// File: rtl/rotary_counter.sv
// Bounded position counter driven by latched rotary encoder events.
// Each event is sampled once in IDLE, applied, then acknowledged via read
// until the decoder has cleared all of its flags.
module rotary_counter #(
  parameter int WIDTH     = 8,
  parameter int MIN_VAL   = 0,
  parameter int MAX_VAL   = 255,
  parameter int STEP_FAST = 10,
  parameter int WRAP      = 1
) (
  input logic             clk,
  input logic             clr,
  rotary_counter_if.slave bus
);
  localparam int W1 = WIDTH + 1;
  // one extra bit so v+step and v+span never overflow
  localparam logic [WIDTH:0] MIN_W  = W1'(MIN_VAL);
  localparam logic [WIDTH:0] MAX_W  = W1'(MAX_VAL);
  localparam logic [WIDTH:0] SPAN_W = W1'(MAX_VAL - MIN_VAL + 1);
  localparam logic [WIDTH:0] FAST_W = W1'(STEP_FAST);
  localparam logic [WIDTH:0] ONE_W  = W1'(1);

  typedef enum logic {IDLE, ACK} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] value_q;
  logic             fast_q, upd_q, err_q, read_c;
  logic             any_flag, take, is_inc, is_dec;
  logic [WIDTH:0]   step, cur, inc, nxt;

  assign any_flag = bus.rotl_in | bus.rotr_in | bus.push_in;
  assign take     = (state_q == IDLE) && any_flag;
  assign is_inc   = bus.rotr_in && !bus.rotl_in;
  assign is_dec   = bus.rotl_in && !bus.rotr_in;

  // state register
  always_ff @(posedge clk) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next state: leave ACK only once the decoder has dropped every flag
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_flag)  state_d = ACK;
      ACK:     if (!any_flag) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM output: read follows the (registered) state
  always_comb begin
    read_c = (state_q == ACK);
  end

  // next position; step uses the pre-toggle fast mode
  always_comb begin
    step = fast_q ? FAST_W : ONE_W;
    cur  = {1'b0, value_q};
    inc  = cur + step;
    nxt  = cur;
    if (is_inc) begin
      if (inc > MAX_W) nxt = (WRAP != 0) ? inc - SPAN_W : MAX_W;
      else             nxt = inc;
    end else if (is_dec) begin
      if (cur < MIN_W + step) nxt = (WRAP != 0) ? cur + SPAN_W - step : MIN_W;
      else                    nxt = cur - step;
    end
  end

  // position, mode, update strobe and sticky error
  always_ff @(posedge clk) begin
    if (clr) begin
      value_q <= MIN_W[WIDTH-1:0];
      fast_q  <= 1'b0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      upd_q <= take && ((nxt != cur) || bus.push_in);
      if (take) begin
        value_q <= nxt[WIDTH-1:0];
        fast_q  <= fast_q ^ bus.push_in;
        if (bus.rotl_in && bus.rotr_in) err_q <= 1'b1;
      end
    end
  end

  assign bus.read  = read_c;
  assign bus.value = value_q;
  assign bus.fast  = fast_q;
  assign bus.upd   = upd_q;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_rotary_counter.sv
// Bench for rotary_counter: one wrapping and one saturating instance driven
// by the same decoder-style event stream, checked against a reference model.
module tb_rotary_counter;
  localparam int MINV = 0;
  localparam int MAXV = 255;
  localparam int SFST = 10;
  localparam int SPAN = MAXV - MINV + 1;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  rotary_counter_if #(.WIDTH(8)) ifw ();
  rotary_counter_if #(.WIDTH(8)) ifs ();

  rotary_counter #(.WIDTH(8), .MIN_VAL(MINV), .MAX_VAL(MAXV), .STEP_FAST(SFST), .WRAP(1))
    u_wrap (.clk(clk), .clr(clr), .bus(ifw));
  rotary_counter #(.WIDTH(8), .MIN_VAL(MINV), .MAX_VAL(MAXV), .STEP_FAST(SFST), .WRAP(0))
    u_sat (.clk(clk), .clr(clr), .bus(ifs));

  typedef struct {
    int vw, vs;
    bit f, uw, us, e;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   mvw, mvs;
  bit   mf, me;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int model_nxt(input int v, input bit l, input bit r,
                                   input bit wrap, input int step);
    if (r && !l) begin
      if (v + step > MAXV) return wrap ? v + step - SPAN : MAXV;
      return v + step;
    end
    if (l && !r) begin
      if (v < MINV + step) return wrap ? v - step + SPAN : MINV;
      return v - step;
    end
    return v;
  endfunction

  task automatic set_flags(input bit l, input bit r, input bit p);
    ifw.rotl_in = l; ifw.rotr_in = r; ifw.push_in = p;
    ifs.rotl_in = l; ifs.rotr_in = r; ifs.push_in = p;
  endtask

  task automatic model_reset();
    mvw = MINV; mvs = MINV; mf = 1'b0; me = 1'b0;
  endtask

  // compute expectation for an event sampled with flags l/r/p, enqueue it
  task automatic push_exp(input bit l, input bit r, input bit p);
    exp_t e;
    int   step;
    step = mf ? SFST : 1;
    e.vw = model_nxt(mvw, l, r, 1'b1, step);
    e.vs = model_nxt(mvs, l, r, 1'b0, step);
    e.uw = (e.vw != mvw) || p;
    e.us = (e.vs != mvs) || p;
    e.f  = mf ^ p;
    e.e  = me | (l & r);
    mvw = e.vw; mvs = e.vs; mf = e.f; me = e.e;
    sbq.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sbq.pop_front();
    chk({tag, "_vw"},   int'(ifw.value), e.vw);
    chk({tag, "_vs"},   int'(ifs.value), e.vs);
    chk({tag, "_fw"},   int'(ifw.fast),  int'(e.f));
    chk({tag, "_fs"},   int'(ifs.fast),  int'(e.f));
    chk({tag, "_uw"},   int'(ifw.upd),   int'(e.uw));
    chk({tag, "_us"},   int'(ifs.upd),   int'(e.us));
    chk({tag, "_ew"},   int'(ifw.err),   int'(e.e));
    chk({tag, "_es"},   int'(ifs.err),   int'(e.e));
    chk({tag, "_rdw"},  int'(ifw.read),  1);
    chk({tag, "_rds"},  int'(ifs.read),  1);
  endtask

  // One decoder event: flags rise, are sampled, held h extra cycles past the
  // decoder's natural clear point, then dropped; read must fall one cycle later.
  task automatic do_evt(input string tag, input bit l, input bit r, input bit p, input int h);
    @(negedge clk);
    set_flags(l, r, p);
    push_exp(l, r, p);
    @(posedge clk);
    @(negedge clk);
    check_out(tag);
    for (int i = 0; i < h + 1; i++) begin
      @(negedge clk);
      chk({tag, "_upd_once"}, int'(ifw.upd) + int'(ifs.upd), 0);
      chk({tag, "_read_hold"}, int'(ifw.read & ifs.read), 1);
      chk({tag, "_hold_vw"}, int'(ifw.value), mvw);
      chk({tag, "_hold_vs"}, int'(ifs.value), mvs);
    end
    set_flags(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk({tag, "_read_drop"}, int'(ifw.read | ifs.read), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    set_flags(1'b0, 1'b0, 1'b0);
    model_reset();
    clr = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_read",  int'(ifw.read | ifs.read), 0);
    chk("rst_value", int'(ifw.value) + int'(ifs.value), 0);
    chk("rst_fast",  int'(ifw.fast | ifs.fast), 0);
    chk("rst_upd",   int'(ifw.upd | ifs.upd), 0);
    chk("rst_err",   int'(ifw.err | ifs.err), 0);
    clr = 1'b0;

    // basic increment, then decrement below MIN (wraps vs clamps)
    do_evt("r1", 1'b0, 1'b1, 1'b0, 0);
    chk("r1_lit", int'(ifw.value), 1);
    do_evt("l1", 1'b1, 1'b0, 1'b0, 0);
    @(negedge clk);
    do_evt("l2", 1'b1, 1'b0, 1'b0, 0);
    chk("wrap_lo_lit", int'(ifw.value), 255);
    chk("sat_lo_lit",  int'(ifs.value), 0);

    // fast mode, drive the saturating copy up into MAX
    do_evt("p1", 1'b0, 1'b0, 1'b1, 0);
    for (int i = 0; i < 26; i++) do_evt("rf", 1'b0, 1'b1, 1'b0, 0);
    chk("sat_hi_lit", int'(ifs.value), 255);
    do_evt("rsat", 1'b0, 1'b1, 1'b0, 0);
    chk("sat_hi_hold", int'(ifs.value), 255);
    for (int i = 0; i < 25; i++) do_evt("lf", 1'b1, 1'b0, 1'b0, 0);
    chk("sat_5_lit", int'(ifs.value), 5);
    do_evt("lsat", 1'b1, 1'b0, 1'b0, 0);
    chk("sat_lo2_lit", int'(ifs.value), 0);

    // back to step 1; walk wrapping copy to 250, then ten steps up across MAX
    do_evt("p2", 1'b0, 1'b0, 1'b1, 0);
    guard = 0;
    while (mvw != 250 && guard < 300) begin
      do_evt("walk", 1'b1, 1'b0, 1'b0, 0);
      guard++;
    end
    for (int i = 0; i < 10; i++) do_evt("r10", 1'b0, 1'b1, 1'b0, 0);
    chk("wrap_hi_lit", int'(ifw.value), 4);

    // push together with rotation uses the old step
    guard = 0;
    while (mvw != 20 && guard < 300) begin
      do_evt("walk2", 1'b0, 1'b1, 1'b0, 0);
      guard++;
    end
    do_evt("pr", 1'b0, 1'b1, 1'b1, 0);
    chk("pr_lit_v", int'(ifw.value), 21);
    chk("pr_lit_f", int'(ifw.fast), 1);
    do_evt("pr2", 1'b0, 1'b1, 1'b0, 0);
    chk("pr2_lit", int'(ifw.value), 31);

    // both directions at once, held long: err sticks, nothing moves twice
    do_evt("both", 1'b1, 1'b1, 1'b0, 5);
    chk("err_lit", int'(ifw.err & ifs.err), 1);
    do_evt("after_err", 1'b1, 1'b0, 1'b0, 1);
    chk("err_sticky", int'(ifw.err & ifs.err), 1);

    // clr mid-handshake with flags still up
    @(negedge clk);
    set_flags(1'b0, 1'b1, 1'b0);
    push_exp(1'b0, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check_out("pre_clr");
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("clr_read",  int'(ifw.read | ifs.read), 0);
    chk("clr_value", int'(ifw.value) + int'(ifs.value), 0);
    chk("clr_fast",  int'(ifw.fast | ifs.fast), 0);
    chk("clr_err",   int'(ifw.err | ifs.err), 0);
    model_reset();
    clr = 1'b0;
    push_exp(1'b0, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check_out("post_clr");
    chk("post_clr_lit", int'(ifw.value), 1);
    set_flags(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_clr_drop", int'(ifw.read | ifs.read), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
